rgb2gray_pipe: RTL and testbench
================================

Name: rgb2gray_pipe

Overview:
- Pipelined, parametrised RGB-to-grayscale converter with a per-frame brightness offset and output saturation.
- Streams one pixel per clock with valid/ready handshakes on both sides, and marks frame ends.
- Counts clamped pixels per frame for image-quality monitoring.
- Sits between the pixel source (camera/RAM reader) and the gray-frame sink in the image pipeline.

Parameters:
- PIX_W, 8, bits per colour channel and per gray output.
- LVL_W, 4, width of brightness level input.
- STEP, 20, pixel-value increment per brightness level.
- WR, 77, red weight (Q0.SHIFT fixed point).
- WG, 150, green weight.
- WB, 29, blue weight.
- SHIFT, 8, right shift applied to the weighted sum; WR+WG+WB must equal 2^SHIFT.
- CNT_W, 16, width of the saturation counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept a pixel this cycle.
- in_r  in  PIX_W  red.
- in_g  in  PIX_W  green.
- in_b  in  PIX_W  blue.
- in_sof  in  1  first pixel of frame; qualified by in_valid & in_ready.
- in_last  in  1  last pixel of frame.
- level  in  LVL_W  brightness level; sampled only on an accepted in_sof beat.
- out_valid  out  1  output pixel valid.
- out_ready  in  1  sink accepts the output pixel.
- out_gray  out  PIX_W  clamped gray value.
- out_last  out  1  travels with the pixel that entered with in_last.
- frame_done  out  1  one-cycle pulse when an out_last beat is accepted.
- sat_cnt  out  CNT_W  number of clamped pixels since the last accepted in_sof.

Behaviour:
- Reset (rst_n=0, async): all stage-valid bits cleared; out_valid=0, out_gray=0, out_last=0, frame_done=0, sat_cnt=0, level register=0. A reset mid-frame discards every in-flight pixel; no partial output appears after release.
- Pipeline has 3 register stages:
  - S1 registers products in_r*WR, in_g*WG, in_b*WB, each PIX_W+SHIFT bits.
  - S2 registers (sum of products) >> SHIFT, plus lvl_q*STEP, with width PIX_W+LVL_W+SHIFT and no overflow.
  - S3 registers the clamp: if the value > 2^PIX_W-1, out_gray = 2^PIX_W-1; otherwise the low PIX_W bits.
- Latency: a pixel accepted in cycle N appears on out_* in cycle N+3 when out_ready has been held high. Throughput is 1 pixel/clock.
- Flow control: a global stall, adv = ~out_valid | out_ready.
  - in_ready = adv.
  - All stages shift only when adv=1; stage valid bits propagate with data, so bubbles are preserved.
  - out_* hold stable while out_valid & ~out_ready.
- in_sof, in_last and the clamp flag ride alongside the data through every stage.
- Level register lvl_q loads level on an accepted in_sof beat; that beat uses the new value, computed combinationally in S1→S2. Level changes without in_sof are ignored.
- Saturation counter:
  - sat_cnt increments when an S3 pixel that was clamped is accepted (out_valid & out_ready).
  - It saturates at 2^CNT_W-1.
  - It is cleared to 0 in the same cycle an in_sof beat is accepted. If a clamped pixel is also accepted that cycle, the count becomes 1 (the clear takes priority, then the count).
- frame_done = out_valid & out_ready & out_last, registered (asserted the cycle after the handshake).
- Protocol: in_valid with in_ready=0 is legal; the source holds the data. The block never drops or duplicates a pixel.

Optional Feature:
- GRAY_ROUND_EN defined: 2^(SHIFT-1) is added to the weighted sum before the shift (round-half-up).
- GRAY_ROUND_EN undefined: the sum is truncated.
- Latency and widths are identical in both builds.

Test Plan:
- r=g=b=255, level=0, in_sof=1 → out_gray=255 after 3 cycles, sat_cnt=0; r=g=b=0 → 0.
- r=g=b=100, level=5 with sof → 100+100=200, no clamp; next pixel with level changed to 9 but no sof → still 200.
- r=g=b=200, level=3 → 260 clamps to 255, sat_cnt=1. A new sof frame then clears sat_cnt to 0 (or to 1 if its first pixel clamps).
- Stream 16 pixels with out_ready toggled randomly at 50% → output sequence equals reference model in order. out_* stable during stalls. Exactly one frame_done, after the in_last pixel.
- Drop rst_n for 1 cycle with 3 pixels in flight → out_valid=0 immediately, sat_cnt=0, and no stale pixel emerges after release.
- r=0, g=1, b=0, level=0 → out_gray=0 without GRAY_ROUND_EN, 1 with GRAY_ROUND_EN ((150+128)>>8).

Source files
------------

// File: rtl/rgb2gray_pipe.sv
// rtl/rgb2gray_pipe.sv - 3-stage RGB-to-gray converter with brightness offset, clamp and saturation counter
// Optional build macro: GRAY_ROUND_EN (round-half-up before the weight shift).
module rgb2gray_pipe #(
    parameter int PIX_W = 8,
    parameter int LVL_W = 4,
    parameter int STEP  = 20,
    parameter int WR    = 77,
    parameter int WG    = 150,
    parameter int WB    = 29,
    parameter int SHIFT = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_r,
    input  logic [PIX_W-1:0] in_g,
    input  logic [PIX_W-1:0] in_b,
    input  logic             in_sof,
    input  logic             in_last,
    input  logic [LVL_W-1:0] level,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_gray,
    output logic             out_last,
    output logic             frame_done,
    output logic [CNT_W-1:0] sat_cnt
);

    localparam int PROD_W = PIX_W + SHIFT;
    localparam int SUM_W  = PIX_W + LVL_W + SHIFT;

    localparam logic [PROD_W-1:0] WR_C    = PROD_W'(WR);
    localparam logic [PROD_W-1:0] WG_C    = PROD_W'(WG);
    localparam logic [PROD_W-1:0] WB_C    = PROD_W'(WB);
    localparam logic [SUM_W-1:0]  STEP_C  = SUM_W'(STEP);
    localparam logic [SUM_W-1:0]  MAX_C   = SUM_W'((1 << PIX_W) - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
`ifdef GRAY_ROUND_EN
    localparam logic [SUM_W-1:0]  RND_C   = SUM_W'(1) << (SHIFT - 1);
`else
    localparam logic [SUM_W-1:0]  RND_C   = '0;
`endif

    logic              adv;
    logic              in_acc;
    logic              out_acc;
    logic [SUM_W-1:0]  wsum;
    logic [SUM_W-1:0]  lvl_term;
    logic              clamp;

    logic [LVL_W-1:0]  lvl_q, lvl_d;
    logic              v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic              last1_q, last1_d, last2_q, last2_d, last3_q, last3_d;
    logic [PROD_W-1:0] prod_r_q, prod_r_d, prod_g_q, prod_g_d, prod_b_q, prod_b_d;
    logic [SUM_W-1:0]  val2_q, val2_d;
    logic [PIX_W-1:0]  gray3_q, gray3_d;
    logic              clamp3_q, clamp3_d;
    logic              fd_q, fd_d;
    logic [CNT_W-1:0]  sat_q, sat_d;

    always_comb begin
        adv      = ~v3_q | out_ready;
        in_acc   = in_valid & adv;
        out_acc  = v3_q & out_ready;

        // The sof beat loads lvl_q at the same edge it enters S1, so it
        // meets the new level one cycle later in S1->S2; older pixels
        // leaving S1 on that same edge still see the previous frame's level.
        lvl_d    = (in_acc & in_sof) ? level : lvl_q;

        wsum     = {{LVL_W{1'b0}}, prod_r_q} + {{LVL_W{1'b0}}, prod_g_q}
                 + {{LVL_W{1'b0}}, prod_b_q} + RND_C;
        lvl_term = {{(SUM_W-LVL_W){1'b0}}, lvl_q} * STEP_C;
        clamp    = val2_q > MAX_C;

        v1_d     = v1_q;
        last1_d  = last1_q;
        prod_r_d = prod_r_q;
        prod_g_d = prod_g_q;
        prod_b_d = prod_b_q;
        v2_d     = v2_q;
        last2_d  = last2_q;
        val2_d   = val2_q;
        v3_d     = v3_q;
        last3_d  = last3_q;
        gray3_d  = gray3_q;
        clamp3_d = clamp3_q;
        if (adv) begin
            v1_d     = in_valid;
            last1_d  = in_last;
            prod_r_d = {{SHIFT{1'b0}}, in_r} * WR_C;
            prod_g_d = {{SHIFT{1'b0}}, in_g} * WG_C;
            prod_b_d = {{SHIFT{1'b0}}, in_b} * WB_C;
            v2_d     = v1_q;
            last2_d  = last1_q;
            val2_d   = (wsum >> SHIFT) + lvl_term;
            v3_d     = v2_q;
            last3_d  = last2_q;
            gray3_d  = clamp ? {PIX_W{1'b1}} : val2_q[PIX_W-1:0];
            clamp3_d = clamp;
        end

        // Clear wins over the count, but a clamped pixel leaving in the
        // clearing cycle still counts toward the new frame.
        sat_d = sat_q;
        if (in_acc & in_sof) begin
            sat_d = (out_acc & clamp3_q) ? CNT_W'(1) : '0;
        end else if (out_acc & clamp3_q & (sat_q != CNT_MAX)) begin
            sat_d = sat_q + CNT_W'(1);
        end

        fd_d = out_acc & last3_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q    <= '0;
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            last1_q  <= 1'b0;
            last2_q  <= 1'b0;
            last3_q  <= 1'b0;
            prod_r_q <= '0;
            prod_g_q <= '0;
            prod_b_q <= '0;
            val2_q   <= '0;
            gray3_q  <= '0;
            clamp3_q <= 1'b0;
            fd_q     <= 1'b0;
            sat_q    <= '0;
        end else begin
            lvl_q    <= lvl_d;
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            v3_q     <= v3_d;
            last1_q  <= last1_d;
            last2_q  <= last2_d;
            last3_q  <= last3_d;
            prod_r_q <= prod_r_d;
            prod_g_q <= prod_g_d;
            prod_b_q <= prod_b_d;
            val2_q   <= val2_d;
            gray3_q  <= gray3_d;
            clamp3_q <= clamp3_d;
            fd_q     <= fd_d;
            sat_q    <= sat_d;
        end
    end

    assign in_ready   = adv;
    assign out_valid  = v3_q;
    assign out_gray   = gray3_q;
    assign out_last   = last3_q;
    assign frame_done = fd_q;
    assign sat_cnt    = sat_q;

endmodule

// File: tb/tb_rgb2gray_pipe.sv
// tb/tb_rgb2gray_pipe.sv - scoreboard bench for rgb2gray_pipe
module tb_rgb2gray_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_r, in_g, in_b;
    logic       in_sof;
    logic       in_last;
    logic [3:0] level;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_gray;
    logic       out_last;
    logic       frame_done;
    logic [15:0] sat_cnt;

    rgb2gray_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .in_sof(in_sof), .in_last(in_last), .level(level),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_gray(out_gray), .out_last(out_last),
        .frame_done(frame_done), .sat_cnt(sat_cnt)
    );

    typedef struct {
        int gray;
        bit last;
        bit clamp;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_cnt = 0;
    int   blvl = 0;
    int   model_sat = 0;
    bit   exp_fd = 0;
    bit   mon_en = 0;
    bit   rand_mode = 0;
    bit   lat_chk = 1;
    bit   prev_stall = 0;
    int   prev_gray = 0;
    bit   prev_last = 0;
    int   fd_cnt = 0;
    int   last_gray = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(posedge clk) begin
        #1;
        out_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model(input int r, input int g, input int b, input int lvl,
                                  output int gray, output bit cl);
        int s;
        s = r * 77 + g * 150 + b * 29;
`ifdef GRAY_ROUND_EN
        s = s + 128;
`endif
        s  = (s >> 8) + lvl * 20;
        cl = (s > 255);
        gray = cl ? 255 : s;
    endfunction

    task automatic send(input int r, input int g, input int b,
                        input bit sof, input bit last, input int lvl);
        int   n = 0;
        exp_t e;
        in_valid = 1'b1;
        in_r = r[7:0];
        in_g = g[7:0];
        in_b = b[7:0];
        in_sof = sof;
        in_last = last;
        level = lvl[3:0];
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check_val("accept_timeout", 0, 1);
        end else begin
            if (sof) blvl = lvl;
            model(r, g, b, blvl, e.gray, e.clamp);
            e.last = last;
            e.cyc = cyc_cnt;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) check_val("drain_timeout", sb.size(), 0);
        idle(3);
    endtask

    // Monitor: everything here is stable at the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            bit   nfd;
            exp_t e;
            check_val("frame_done", int'(frame_done), int'(exp_fd));
            check_val("sat_cnt", int'(sat_cnt), model_sat);
            if (prev_stall) begin
                check_val("stall_valid", int'(out_valid), 1);
                check_val("stall_gray", int'(out_gray), prev_gray);
                check_val("stall_last", int'(out_last), int'(prev_last));
            end
            nfd = out_valid & out_ready & out_last;
            if (in_valid && in_ready && in_sof) model_sat = 0;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_val("unexpected_out", int'(out_gray), -1);
                end else begin
                    e = sb.pop_front();
                    check_val("gray", int'(out_gray), e.gray);
                    check_val("last", int'(out_last), int'(e.last));
                    if (lat_chk) check_val("latency", cyc_cnt - e.cyc, 3);
                    if (e.clamp && model_sat != 65535) model_sat++;
                    last_gray = out_gray;
                end
            end
            if (frame_done) fd_cnt++;
            prev_stall = out_valid & ~out_ready;
            prev_gray  = out_gray;
            prev_last  = out_last;
            exp_fd     = nfd;
        end
    end

    initial begin
        int fd0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_r = '0; in_g = '0; in_b = '0;
        in_sof = 1'b0; in_last = 1'b0; level = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_out_valid", int'(out_valid), 0);
        check_val("rst_out_gray", int'(out_gray), 0);
        check_val("rst_out_last", int'(out_last), 0);
        check_val("rst_frame_done", int'(frame_done), 0);
        check_val("rst_sat_cnt", int'(sat_cnt), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        check_val("idle_in_ready", int'(in_ready), 1);

        // White and black, level 0
        send(255, 255, 255, 1, 0, 0);
        send(0, 0, 0, 0, 1, 0);
        drain();
        check_val("sat_after_white", int'(sat_cnt), 0);

        // Level 5 applies; a later level change without sof is ignored
        send(100, 100, 100, 1, 0, 5);
        send(100, 100, 100, 0, 1, 9);
        drain();
        check_val("last_gray_lvl_hold", last_gray, 200);

        // Clamp: 200 + 3*20 = 260 -> 255
        send(200, 200, 200, 1, 1, 3);
        drain();
        check_val("sat_after_clamp", int'(sat_cnt), 1);
        check_val("clamp_gray", last_gray, 255);

        // Back-to-back frames: new sof lands on the same cycle as a clamped output
        send(200, 200, 200, 1, 0, 3);
        send(200, 200, 200, 0, 0, 3);
        send(200, 200, 200, 0, 0, 3);
        send(200, 200, 200, 0, 1, 3);
        send(10, 10, 10, 1, 1, 0);
        drain();
        check_val("sat_clear_priority", int'(sat_cnt), 3);

        // Random stream with random backpressure
        fd0 = fd_cnt;
        rand_mode = 1'b1;
        lat_chk = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)), i == 0, i == 15, int'($urandom_range(0, 15)));
        end
        drain();
        rand_mode = 1'b0;
        idle(2);
        lat_chk = 1'b1;
        check_val("frame_done_count", fd_cnt - fd0, 1);

        // Reset with three pixels in flight
        send(200, 200, 200, 1, 0, 7);
        send(90, 90, 90, 0, 0, 7);
        send(30, 30, 30, 0, 0, 7);
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check_val("midrst_out_valid", int'(out_valid), 0);
        check_val("midrst_sat_cnt", int'(sat_cnt), 0);
        check_val("midrst_frame_done", int'(frame_done), 0);
        sb.delete();
        model_sat = 0;
        exp_fd = 0;
        prev_stall = 0;
        blvl = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        idle(8);
        check_val("post_rst_quiet", int'(out_valid), 0);
        send(50, 50, 50, 0, 1, 9);
        drain();
        check_val("post_rst_lvl0", last_gray, 50);

        // Rounding corner: 150 >> 8 truncates to 0, rounds to 1
        send(0, 1, 0, 1, 1, 0);
        drain();
`ifdef GRAY_ROUND_EN
        check_val("round_g1", last_gray, 1);
`else
        check_val("round_g1", last_gray, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
